seg_scan_decoder: RTL and testbench

- Receive-side companion to the team's seven-segment hex encoder/driver: observes a multiplexed 4-digit, active-low anode/cathode bus and reconstructs the displayed 16-bit hex value.
- Used for loopback self-check of the display path and for reading a display bus driven by another board.
- Synchronises the inputs and debounces each digit dwell.
- Decodes segment patterns back to nibbles and emits a complete frame once all four digits have been captured.

---
 rtl/seg_scan_decoder.sv | 199 +++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed 4-digit, active-low seven-segment
// bus and rebuilds the 16-bit hex value being displayed. Each digit must dwell
// with a stable pattern for STABLE_CYCLES synchronised samples before it is
// captured. A frame is published once all four digits have been seen.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic [3:0]  bad,
  output logic        frame_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  // {an, seg} through two synchroniser flops, plus the previous sample
  logic [10:0] sync1;
  logic [10:0] samp;
  logic [10:0] prev;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        capture;

  logic [3:0]  an_act;
  logic        an_ok;
  logic [3:0]  dec_nib;
  logic        dec_blank;
  logic        dec_bad;

  logic [15:0] sh_value;
  logic [3:0]  sh_blank;
  logic [3:0]  sh_bad;
  logic [3:0]  mask;

  logic [15:0] new_value;
  logic [3:0]  new_blank;
  logic [3:0]  new_bad;
  logic [3:0]  new_mask;

  // Input synchroniser and previous-sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      samp  <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {an, seg};
      samp  <= sync1;
      prev  <= samp;
    end
  end

  // Anode validity: exactly one active (low) anode
  always_comb begin
    an_act = ~samp[10:7];
    an_ok  = (an_act != '0) && ((an_act & (an_act - 4'd1)) == '0);
  end

  // Segment pattern (a..g, active-low) back to a nibble
  always_comb begin
    dec_nib   = '0;
    dec_blank = 1'b0;
    dec_bad   = 1'b0;
    case (samp[6:0])
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_bad   = 1'b1;
    endcase
  end

  // Dwell FSM state and stability counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Dwell FSM next state: capture fires on the edge after the counter has
  // reached the limit, so a held change is captured STABLE_CYCLES+2 edges later
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!an_ok) begin
          cnt_nxt = '0;
        end else begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd1;
        end
      end
      SETTLE: begin
        if (samp != prev) begin
          cnt_nxt = 8'd1;
        end else if (!an_ok) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LIMIT) begin
          capture   = 1'b1;
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HELD: begin
        if (samp != prev) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd1;
        end else if (!an_ok) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Shadow contents with the current capture merged into the selected slot
  always_comb begin
    new_value = sh_value;
    new_blank = sh_blank;
    new_bad   = sh_bad;
    for (int unsigned j = 0; j < 4; j++) begin
      if (an_act[j]) begin
        new_value[4*j +: 4] = dec_nib;
        new_blank[j]        = dec_blank;
        new_bad[j]          = dec_bad;
      end
    end
    new_mask = mask | an_act;
  end

  // Shadow slots, capture mask and published frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_value    <= '0;
      sh_blank    <= '0;
      sh_bad      <= '0;
      mask        <= '0;
      value       <= '0;
      blank       <= '1;
      bad         <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (capture) begin
        sh_value <= new_value;
        sh_blank <= new_blank;
        sh_bad   <= new_bad;
        if (new_mask == 4'hF) begin
          value       <= new_value;
          blank       <= new_blank;
          bad         <= new_bad;
          frame_valid <= 1'b1;
          mask        <= '0;
        end else begin
          mask <= new_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with hand-computed expectations.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  bad;
  logic        frame_valid;

  int n_total = 0;
  int n_bad   = 0;
  int fv_count = 0;
  int fv_base;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PE = 7'b0110000;
  localparam logic [6:0] PBLANK = 7'b1111111;
  localparam logic [6:0] PILL   = 7'b1110111;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .blank       (blank),
    .bad         (bad),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_valid) fv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int idx, input logic [6:0] pat);
    logic [3:0] sel;
    sel = 4'b0001 << idx;
    an  = ~sel;
    seg = pat;
  endtask

  task automatic scan(input int idx, input logic [6:0] pat);
    drive(idx, pat);
    tick(8);
  endtask

  // last digit of a frame: frame_valid must rise after edge 6 for one cycle
  task automatic scan_last(input int idx, input logic [6:0] pat, input string tag);
    drive(idx, pat);
    tick(6);
    check({tag, "_fv_e5"}, 32'(frame_valid), 0);
    tick(1);
    check({tag, "_fv_e6"}, 32'(frame_valid), 1);
    tick(1);
    check({tag, "_fv_e7"}, 32'(frame_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    tick(2);
    check("rst_value", 32'(value), 32'h0000);
    check("rst_blank", 32'(blank), 32'hF);
    check("rst_bad", 32'(bad), 32'h0);
    check("rst_fv", 32'(frame_valid), 0);
    rst = 1'b0;
    tick(2);

    // static single digit
    fv_base = fv_count;
    drive(0, P2);
    tick(6);
    check("static_mask_e5", 32'(dut.mask), 32'h0);
    tick(1);
    check("static_mask_e6", 32'(dut.mask), 32'h1);
    tick(13);
    check("static_mask_hold", 32'(dut.mask), 32'h1);
    check("static_fv", 32'(fv_count - fv_base), 0);
    check("static_value", 32'(value), 32'h0000);

    // clean slate for the full scan
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    an = 4'hF;
    tick(2);

    // full scan 1,2,4,A
    fv_base = fv_count;
    scan(3, P1);
    scan(2, P2);
    scan(1, P4);
    scan_last(0, PA, "scan124A");
    check("scan_value", 32'(value), 32'h124A);
    check("scan_blank", 32'(blank), 32'h0);
    check("scan_bad", 32'(bad), 32'h0);
    check("scan_fvcnt", 32'(fv_count - fv_base), 1);
    check("scan_mask", 32'(dut.mask), 32'h0);

    // glitch rejection: pattern changes every 3 cycles
    fv_base = fv_count;
    for (int k = 0; k < 10; k++) begin
      drive(0, (k % 2 == 0) ? P1 : P2);
      tick(3);
    end
    check("glitch_mask", 32'(dut.mask), 32'h0);
    an = 4'hF;
    tick(10);
    check("glitch_mask_idle", 32'(dut.mask), 32'h0);
    check("glitch_fv", 32'(fv_count - fv_base), 0);
    check("glitch_value_hold", 32'(value), 32'h124A);

    // blank and illegal patterns
    fv_base = fv_count;
    scan(3, P0);
    scan(2, PBLANK);
    scan(1, PILL);
    scan_last(0, P0, "blankbad");
    check("bb_value", 32'(value), 32'h0000);
    check("bb_blank", 32'(blank), 32'h4);
    check("bb_bad", 32'(bad), 32'h2);
    check("bb_fvcnt", 32'(fv_count - fv_base), 1);

    // invalid anodes never capture
    fv_base = fv_count;
    an = 4'b1100; seg = PE;
    tick(50);
    check("inv_multi_mask", 32'(dut.mask), 32'h0);
    an = 4'b1111;
    tick(50);
    check("inv_none_mask", 32'(dut.mask), 32'h0);
    check("inv_fv", 32'(fv_count - fv_base), 0);
    drive(3, PE);
    tick(6);
    check("inv_e_mask_e5", 32'(dut.mask), 32'h0);
    tick(1);
    check("inv_e_mask_e6", 32'(dut.mask), 32'h8);
    check("inv_e_slot3", 32'(dut.sh_value[15:12]), 32'hE);
    tick(1);

    // two more digits, then asynchronous reset between edges
    scan(2, P1);
    scan(1, P2);
    check("mid_mask", 32'(dut.mask), 32'hE);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_value", 32'(value), 32'h0000);
    check("mid_rst_blank", 32'(blank), 32'hF);
    check("mid_rst_bad", 32'(bad), 32'h0);
    check("mid_rst_mask", 32'(dut.mask), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    an = 4'hF;
    tick(2);

    // full scan of 8,8,8,8
    fv_base = fv_count;
    scan(3, P8);
    scan(2, P8);
    scan(1, P8);
    scan_last(0, P8, "scan8888");
    check("s8_value", 32'(value), 32'h8888);
    check("s8_blank", 32'(blank), 32'h0);
    check("s8_bad", 32'(bad), 32'h0);
    tick(20);
    check("s8_fvcnt", 32'(fv_count - fv_base), 1);
    check("s8_value_hold", 32'(value), 32'h8888);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
